psx_host_poller: RTL and testbench

Console-side initiator for the PSX controller serial link, the host that drives a psx_controller device. On a start request it asserts att, clocks out the standard poll command sequence on cmd/psx_clk, samples data and waits on ack between bytes. Latches the digital button word and device ID for the game logic. Sits between the game core (clk domain) and the controller pins.

---
 rtl/psx_host_poller.sv | 234 +++++++++++++++++++++++
 tb/tb_psx_host_poller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_host_poller.sv
// Host-side poller for the PSX controller serial link: runs the 5-byte poll and latches ID/buttons.
// Optional macro PSX_ANALOG_EN: analog-red (ID 0x73) polls extend to 9 bytes and drive `analog`.
module psx_host_poller #(
  parameter int unsigned CLK_HALF    = 4,
  parameter int unsigned ATT_SETUP   = 8,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned BYTE_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        data,
  input  logic        ack,
  output logic        psx_clk,
  output logic        cmd,
  output logic        att,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  dev_id,
  output logic [15:0] buttons
`ifdef PSX_ANALOG_EN
  ,
  output logic [31:0] analog
`endif
);

  localparam logic [15:0] HalfLast  = 16'(CLK_HALF - 1);
  localparam logic [15:0] SetupLast = 16'(ATT_SETUP - 1);
  localparam logic [15:0] AckLast   = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GapLast   = 16'(BYTE_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StAttSetup, StBitLow, StBitHigh, StWaitAck, StGap, StAttHold, StFinish
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [3:0]  byte_q;
  logic [7:0]  shift_q, cur_cmd_q, id_q, b3_q, b4_q;
  logic        data_s1, data_s2, ack_s1, ack_s2;
  logic [7:0]  rx_byte, next_cmd;
  logic [3:0]  last_byte;
`ifdef PSX_ANALOG_EN
  logic [31:0] an_q;
`endif

  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h42;
      default: return 8'h00;
    endcase
  endfunction

  assign rx_byte  = {data_s2, shift_q[7:1]};
  assign next_cmd = cmd_byte(byte_q + 4'd1);
`ifdef PSX_ANALOG_EN
  assign last_byte = (id_q == 8'h73) ? 4'd8 : 4'd4;
`else
  assign last_byte = 4'd4;
`endif

  // data and ack are asynchronous to clk; idle levels are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      ack_s1  <= 1'b1;
      ack_s2  <= 1'b1;
    end else begin
      data_s1 <= data;
      data_s2 <= data_s1;
      ack_s1  <= ack;
      ack_s2  <= ack_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      cur_cmd_q <= '0;
      id_q      <= 8'hFF;
      b3_q      <= 8'hFF;
      b4_q      <= 8'hFF;
      psx_clk   <= 1'b1;
      cmd       <= 1'b1;
      att       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dev_id    <= 8'hFF;
      buttons   <= 16'hFFFF;
`ifdef PSX_ANALOG_EN
      an_q      <= 32'h80808080;
      analog    <= 32'h80808080;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            att       <= 1'b0;
            busy      <= 1'b1;
            err       <= 1'b0;
            byte_q    <= '0;
            cur_cmd_q <= cmd_byte(4'd0);
            cnt_q     <= '0;
            state_q   <= StAttSetup;
          end
        end
        StAttSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            psx_clk <= 1'b0;
            cmd     <= cur_cmd_q[0];
            state_q <= StBitLow;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StBitLow: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            psx_clk <= 1'b1;
            state_q <= StBitHigh;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StBitHigh: begin
          if (cnt_q == HalfLast) begin
            // Late sample in the high phase covers the two-flop synchronizer delay.
            cnt_q   <= '0;
            shift_q <= rx_byte;
            if (bit_q != 3'd7) begin
              bit_q   <= bit_q + 3'd1;
              psx_clk <= 1'b0;
              cmd     <= cur_cmd_q[bit_q + 3'd1];
              state_q <= StBitLow;
            end else begin
              cmd <= 1'b1;
              case (byte_q)
                4'd1: id_q <= rx_byte;
                4'd3: b3_q <= rx_byte;
                4'd4: b4_q <= rx_byte;
`ifdef PSX_ANALOG_EN
                4'd5: an_q[7:0]   <= rx_byte;
                4'd6: an_q[15:8]  <= rx_byte;
                4'd7: an_q[23:16] <= rx_byte;
                4'd8: an_q[31:24] <= rx_byte;
`endif
                default: ;
              endcase
              if (byte_q == 4'd2 && rx_byte != 8'h5A) begin
                err     <= 1'b1;
                state_q <= StAttHold;
              end else if (byte_q == last_byte) begin
                state_q <= StAttHold;
              end else begin
                state_q <= StWaitAck;
              end
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StWaitAck: begin
          if (!ack_s2) begin
            cnt_q   <= '0;
            state_q <= StGap;
          end else if (cnt_q == AckLast) begin
            err     <= 1'b1;
            cnt_q   <= '0;
            state_q <= StAttHold;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StGap: begin
          if (cnt_q >= GapLast && ack_s2) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= byte_q + 4'd1;
            cur_cmd_q <= next_cmd;
            psx_clk   <= 1'b0;
            cmd       <= next_cmd[0];
            state_q   <= StBitLow;
          end else if (cnt_q == AckLast) begin
            err     <= 1'b1;
            cnt_q   <= '0;
            state_q <= StAttHold;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StAttHold: begin
          if (cnt_q == SetupLast) begin
            att     <= 1'b1;
            cnt_q   <= '0;
            state_q <= StFinish;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StFinish: begin
          // Keeping busy through this wait guarantees att stays high between polls.
          if (cnt_q == SetupLast) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
            if (!err) begin
              dev_id  <= id_q;
              buttons <= {b4_q, b3_q};
`ifdef PSX_ANALOG_EN
              if (byte_q == 4'd8) analog <= an_q;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psx_host_poller.sv
// Bench for psx_host_poller: a behavioural controller answers each poll; expected command bytes
// and transaction results are queued at stimulus time and checked as the DUT produces them.
module tb_psx_host_poller;

  typedef struct packed {
    logic        err;
    logic [7:0]  id;
    logic [15:0] btn;
    logic [31:0] an;
    logic [7:0]  nb;
  } res_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        data  = 1'b1;
  logic        ack   = 1'b1;
  logic        psx_clk, cmd, att, busy, done, err;
  logic [7:0]  dev_id;
  logic [15:0] buttons;
`ifdef PSX_ANALOG_EN
  logic [31:0] analog;
`endif

  psx_host_poller #(
    .CLK_HALF(4), .ATT_SETUP(8), .ACK_TIMEOUT(64), .BYTE_GAP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .ack(ack),
    .psx_clk(psx_clk), .cmd(cmd), .att(att), .busy(busy), .done(done), .err(err),
    .dev_id(dev_id), .buttons(buttons)
`ifdef PSX_ANALOG_EN
    , .analog(analog)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int cyc = 0, done_cnt = 0, att_falls = 0, hi_cnt = 0, min_gap = 1000;
  int bit_cnt = 0, byte_cnt = 0, fall_cnt = 0, ack_last = 3;
  int t_att = 0, t_f0 = 0, t_f1 = 0;
  logic [7:0] resp [9];
  logic [7:0] rx_cmd = 8'h00;
  logic [7:0] exp_cmd_q [$];
  res_t       exp_res_q [$];
  res_t       mon_r;
  event       ack_ev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (att) hi_cnt++;
  end

  // Behavioural controller: shifts resp out on psx_clk falls, captures cmd on rises.
  always @(negedge att) begin
    att_falls++;
    if (hi_cnt < min_gap) min_gap = hi_cnt;
    hi_cnt   = 0;
    bit_cnt  = 0;
    byte_cnt = 0;
    fall_cnt = 0;
    t_att    = cyc;
  end

  always @(posedge att) data = 1'b1;

  always @(negedge psx_clk) begin
    if (rst_n && !att) begin
      if (byte_cnt == 0 && fall_cnt == 0) t_f0 = cyc;
      if (byte_cnt == 0 && fall_cnt == 1) t_f1 = cyc;
      fall_cnt++;
      data = (byte_cnt < 9) ? resp[byte_cnt][bit_cnt] : 1'b1;
    end
  end

  always @(posedge psx_clk) begin
    if (rst_n && !att) begin
      rx_cmd[bit_cnt] = cmd;
      if (bit_cnt == 7) begin
        check("cmd_q_nonempty", 32'(exp_cmd_q.size() != 0), 32'd1);
        if (exp_cmd_q.size() != 0)
          check($sformatf("cmd_byte%0d", byte_cnt), 32'(rx_cmd), 32'(exp_cmd_q.pop_front()));
        if (byte_cnt <= ack_last) -> ack_ev;
        byte_cnt++;
        bit_cnt = 0;
      end else begin
        bit_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(ack_ev);
      repeat (6) @(negedge clk);
      ack = 1'b0;
      repeat (2) @(negedge clk);
      ack = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      check("res_q_nonempty", 32'(exp_res_q.size() != 0), 32'd1);
      if (exp_res_q.size() != 0) begin
        mon_r = exp_res_q.pop_front();
        check("done_err", 32'(err), 32'(mon_r.err));
        check("done_dev_id", 32'(dev_id), 32'(mon_r.id));
        check("done_buttons", 32'(buttons), 32'(mon_r.btn));
        check("done_bytes", 32'(byte_cnt), 32'(mon_r.nb));
        check("done_busy", 32'(busy), 32'd0);
`ifdef PSX_ANALOG_EN
        check("done_analog", analog, mon_r.an);
`endif
      end
    end
  end

  task automatic set_resp(input logic [7:0] id, input logic [7:0] hdr, input logic [7:0] b3,
                          input logic [7:0] b4);
    resp[0] = 8'hFF; resp[1] = id; resp[2] = hdr; resp[3] = b3; resp[4] = b4;
    resp[5] = 8'h10; resp[6] = 8'h20; resp[7] = 8'h30; resp[8] = 8'h40;
  endtask

  task automatic push_cmds(input int n);
    for (int i = 0; i < n; i++)
      exp_cmd_q.push_back((i == 0) ? 8'h01 : (i == 1) ? 8'h42 : 8'h00);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int i = 0;
    while (done_cnt < target && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    int base;
    int abase;
    set_resp(8'h41, 8'h5A, 8'hFE, 8'h7F);
    repeat (3) @(negedge clk);
    check("rst_pins", {29'd0, att, psx_clk, cmd}, 32'h7);
    check("rst_flags", {29'd0, busy, done, err}, 32'h0);
    check("rst_dev_id", 32'(dev_id), 32'hFF);
    check("rst_buttons", 32'(buttons), 32'hFFFF);
`ifdef PSX_ANALOG_EN
    check("rst_analog", analog, 32'h80808080);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset asserted in the middle of byte 2.
    ack_last = 3;
    push_cmds(2);
    pulse_start();
    for (int i = 0; i < 3000 && !(byte_cnt == 2 && psx_clk == 1'b0); i++) @(negedge clk);
    check("t1_reach_byte2", 32'(byte_cnt == 2 && psx_clk == 1'b0), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_async_pins", {29'd0, att, psx_clk, cmd}, 32'h7);
    check("t1_async_busy", 32'(busy), 32'd0);
    check("t1_async_buttons", 32'(buttons), 32'hFFFF);
    check("t1_cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Nominal poll, with an extra start while busy that must be ignored.
    base = done_cnt;
    push_cmds(5);
    exp_res_q.push_back('{err: 1'b0, id: 8'h41, btn: 16'h7FFE, an: 32'h80808080, nb: 8'd5});
    pulse_start();
    check("t2_busy_att", {30'd0, busy, att}, 32'h2);
    repeat (30) @(negedge clk);
    pulse_start();
    wait_done(base + 1);
    check("t2_att_setup_cycles", 32'(t_f0 - t_att), 32'd8);
    check("t2_psx_clk_period", 32'(t_f1 - t_f0), 32'd8);
    repeat (40) @(negedge clk);
    check("t2_single_done", 32'(done_cnt), 32'(base + 1));

    // Ack timeout after byte 2; a different ID must not be latched.
    set_resp(8'h23, 8'h5A, 8'h00, 8'h00);
    ack_last = 1;
    base = done_cnt;
    push_cmds(3);
    exp_res_q.push_back('{err: 1'b1, id: 8'h41, btn: 16'h7FFE, an: 32'h80808080, nb: 8'd3});
    pulse_start();
    wait_done(base + 1);
    repeat (10) @(negedge clk);
    check("t3_err_held", {30'd0, err, att}, 32'h3);

    // Bad header: byte 2 returns 0x00.
    set_resp(8'h99, 8'h00, 8'h11, 8'h22);
    ack_last = 3;
    base = done_cnt;
    push_cmds(3);
    exp_res_q.push_back('{err: 1'b1, id: 8'h41, btn: 16'h7FFE, an: 32'h80808080, nb: 8'd3});
    pulse_start();
    check("t4_err_cleared", 32'(err), 32'd0);
    wait_done(base + 1);
    repeat (20) @(negedge clk);

    // start held high: back-to-back polls.
    set_resp(8'h41, 8'h5A, 8'hFE, 8'h7F);
    base = done_cnt;
    abase = att_falls;
    min_gap = 1000;
    for (int k = 0; k < 3; k++) begin
      push_cmds(5);
      exp_res_q.push_back('{err: 1'b0, id: 8'h41, btn: 16'h7FFE, an: 32'h80808080, nb: 8'd5});
    end
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 5000 && att_falls < abase + 3; i++) @(negedge clk);
    start = 1'b0;
    wait_done(base + 3);
    repeat (200) @(negedge clk);
    check("t5_done_count", 32'(done_cnt), 32'(base + 3));
    check("t5_poll_count", 32'(att_falls), 32'(abase + 3));
    check("t5_att_gap_ok", 32'(min_gap >= 8), 32'd1);

`ifdef PSX_ANALOG_EN
    // Analog-red ID extends to 9 bytes; a digital ID afterwards leaves analog alone.
    set_resp(8'h73, 8'h5A, 8'hFE, 8'h7F);
    ack_last = 7;
    base = done_cnt;
    push_cmds(9);
    exp_res_q.push_back('{err: 1'b0, id: 8'h73, btn: 16'h7FFE, an: 32'h40302010, nb: 8'd9});
    pulse_start();
    wait_done(base + 1);
    repeat (20) @(negedge clk);
    set_resp(8'h41, 8'h5A, 8'hFE, 8'h7F);
    ack_last = 3;
    push_cmds(5);
    exp_res_q.push_back('{err: 1'b0, id: 8'h41, btn: 16'h7FFE, an: 32'h40302010, nb: 8'd5});
    pulse_start();
    wait_done(base + 2);
    repeat (20) @(negedge clk);
`endif

    check("final_cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
    check("final_res_q_empty", 32'(exp_res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
